// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 stream multiplexer.
// rr_next does the wrap-around search that the round-robin arbiter uses.
package mux_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

    // Widest request vector rr_next can handle.
    localparam int RR_MAX_N = 256;

    // Select width for n channels; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester found after ptr, wrapping modulo n; -1 when nobody requests.
    function automatic int rr_next(input int n, input int ptr, input logic [RR_MAX_N-1:0] req);
        int idx;
        int k;
        idx = -1;
        for (int i = 1; i <= n; i++) begin
            k = (ptr + i) % n;
            if (idx < 0 && req[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: lowest requester strictly after ptr, wrapping.
// Holds no state; the caller owns the pointer.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    int nxt;

    always_comb begin
        nxt     = rr_next(N, int'(ptr), RR_MAX_N'(req));
        gnt_any = (nxt >= 0);
        gnt_idx = gnt_any ? SW'(nxt) : '0;
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// Registered N-to-1 valid/ready stream mux with per-packet channel lock.
// Channel chosen by sel (mode 0) or round-robin (mode 1), held until in_last.
//
//  state | meaning
//  IDLE  | no packet open; sample mode/sel and pick a candidate channel
//  LOCK  | packet open on grant; pass beats until a transfer carries in_last
module mux_nto1_stream
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 8,
    localparam int SW = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
);

    // Valid/last widened to the full select range so any sel value indexes safely.
    localparam int NP = 1 << SW;

    mux_state_t    state;
    logic [SW-1:0] grant;
    logic [SW-1:0] rr_ptr;

    logic [NP-1:0] valid_pad;
    logic [NP-1:0] last_pad;
    logic          sel_in_range;
    logic [SW-1:0] arb_idx;
    logic          arb_any;
    logic [SW-1:0] cand_idx;
    logic          cand_any;
    logic          lock_rdy;
    logic          xfer;
    logic          xfer_last;
    logic [W-1:0]  grant_data;

    assign valid_pad    = NP'(in_valid);
    assign last_pad     = NP'(in_last);
    assign sel_in_range = int'(sel) < N;

    rr_arbiter_n #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        cand_any = 1'b0;
        cand_idx = '0;
        if (mode) begin
            cand_any = arb_any;
            cand_idx = arb_idx;
        end else begin
            cand_any = sel_in_range && valid_pad[sel];
            cand_idx = sel;
        end
    end

    // Ready is a function of state and the output register only, never of in_valid.
    assign lock_rdy   = (state == LOCK) && (!out_valid || out_ready);
    assign in_ready   = lock_rdy ? (N'(1) << grant) : '0;
    assign xfer       = lock_rdy && valid_pad[grant];
    assign xfer_last  = xfer && last_pad[grant];
    assign grant_data = in_data[int'(grant)*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= SW'(N - 1);
        end else if (state == IDLE) begin
            if (cand_any) begin
                grant <= cand_idx;
                state <= LOCK;
            end
        end else begin
            if (xfer_last) begin
                state  <= IDLE;
                rr_ptr <= grant;
            end
        end
    end

    // Single-entry output stage: reload on transfer, otherwise drain on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_last  <= last_pad[grant];
            out_ch    <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: directed scenarios plus a randomized run
// scored against per-channel beat queues and packet atomicity.
module tb_mux_nto1_stream;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [SW-1:0]  out_ch;
    logic           out_ready;

    logic [6*W-1:0] in6_data;
    logic [5:0]     in6_valid;
    logic [5:0]     in6_last;
    logic [5:0]     in6_ready;
    logic           mode6;
    logic [2:0]     sel6;
    logic [W-1:0]   out6_data;
    logic           out6_valid;
    logic           out6_last;
    logic [2:0]     out6_ch;
    logic           out6_ready;

    always #5 clk = ~clk;

    mux_nto1_stream #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .mode(mode), .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ch(out_ch), .out_ready(out_ready)
    );

    mux_nto1_stream #(.N(6), .W(W)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in6_data), .in_valid(in6_valid),
        .in_last(in6_last), .in_ready(in6_ready), .mode(mode6), .sel(sel6),
        .out_data(out6_data), .out_valid(out6_valid), .out_last(out6_last),
        .out_ch(out6_ch), .out_ready(out6_ready)
    );

    typedef struct packed {
        logic       l;
        logic [7:0] d;
    } beat_t;

    beat_t src_q [N][$];   // beats each source still has to offer
    beat_t exp_q [N][$];   // beats accepted from a source, not yet seen at the output
    beat_t obs_b [$];
    int    obs_ch [$];
    int    obs_cyc [$];

    int cyc = 0;
    int gate_pct = 100;
    int ready_pct = 100;
    int checks = 0;
    int errors = 0;

    // One clock of the source/sink models: observe handshakes, then drive the next inputs.
    task automatic cycle();
        logic [N-1:0] acc;
        logic         hold;
        acc = '0;
        @(negedge clk);
        if (out_valid && out_ready) begin
            obs_b.push_back({out_last, out_data});
            obs_ch.push_back(int'(out_ch));
            obs_cyc.push_back(cyc);
        end
        for (int k = 0; k < N; k++) begin
            if (in_valid[k] && in_ready[k]) begin
                acc[k] = 1'b1;
                exp_q[k].push_back(src_q[k][0]);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) void'(src_q[k].pop_front());
            hold = in_valid[k] && !acc[k];
            in_valid[k] = hold || (src_q[k].size() > 0 && $urandom_range(99) < gate_pct);
            if (in_valid[k]) begin
                in_data[k*W +: W] = src_q[k][0].d;
                in_last[k]        = src_q[k][0].l;
            end else begin
                in_data[k*W +: W] = 8'($urandom);
                in_last[k]        = 1'($urandom);
            end
        end
        out_ready = $urandom_range(99) < ready_pct;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        in6_valid = '0; in6_last = '0; in6_data = '0; out6_ready = 1'b0;
        mode6 = 1'b0; sel6 = '0;
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
        end
        obs_b.delete(); obs_ch.delete(); obs_cyc.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mode = 1'b1; sel = '0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
        checks++; if (out_ch !== 3'd0) begin errors++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
        checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready got %h exp 00", in_ready); end
        checks++; if (out6_valid !== 1'b0) begin errors++; $display("FAIL reset_out6_valid got %b exp 0", out6_valid); end
    endtask

    task automatic test_mode0();
        int n;
        do_reset();
        mode = 1'b0; sel = 3'd5; gate_pct = 100; ready_pct = 100;
        for (int i = 0; i < 4; i++) src_q[5].push_back({i == 3, 8'(8'hA0 + i)});
        src_q[2].push_back({1'b1, 8'h22});
        n = 0;
        while (obs_b.size() < 4 && n < 30) begin
            cycle();
            n++;
            checks++; if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL m0_unselected_ready got %b exp 0", in_ready[2]); end
        end
        checks++;
        if (obs_b.size() != 4) begin
            errors++; $display("FAIL m0_beat_count got %0d exp 4", obs_b.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_b[i].d !== 8'(8'hA0 + i)) begin errors++; $display("FAIL m0_data[%0d] got %h exp %h", i, obs_b[i].d, 8'(8'hA0 + i)); end
                checks++; if (obs_b[i].l !== (i == 3)) begin errors++; $display("FAIL m0_last[%0d] got %b exp %b", i, obs_b[i].l, i == 3); end
                checks++; if (obs_ch[i] != 5) begin errors++; $display("FAIL m0_ch[%0d] got %0d exp 5", i, obs_ch[i]); end
                if (i > 0) begin
                    checks++; if (obs_cyc[i] - obs_cyc[i-1] != 1) begin errors++; $display("FAIL m0_gap[%0d] got %0d exp 1", i, obs_cyc[i] - obs_cyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_sel_invalid();
        do_reset();
        mode6 = 1'b0; in6_valid = 6'h3F; in6_last = 6'h3F; out6_ready = 1'b1;
        for (int j = 0; j < 6; j++) in6_data[j*W +: W] = 8'(8'h60 + j);
        for (int s = 6; s < 8; s++) begin
            sel6 = 3'(s);
            repeat (4) begin
                @(posedge clk); #1;
                checks++; if (in6_ready !== 6'h00) begin errors++; $display("FAIL sel_oor_ready sel=%0d got %h exp 00", s, in6_ready); end
                checks++; if (out6_valid !== 1'b0) begin errors++; $display("FAIL sel_oor_valid sel=%0d got %b exp 0", s, out6_valid); end
            end
        end
        sel6 = 3'd2;
        @(posedge clk); #1;
        checks++; if (in6_ready !== 6'b000100) begin errors++; $display("FAIL sel6_grant_ready got %b exp 000100", in6_ready); end
        @(posedge clk); #1;
        in6_valid = '0;
        checks++; if (out6_valid !== 1'b1 || out6_ch !== 3'd2 || out6_data !== 8'h62 || out6_last !== 1'b1) begin
            errors++; $display("FAIL sel6_beat got v=%b ch=%0d d=%h l=%b exp v=1 ch=2 d=62 l=1", out6_valid, out6_ch, out6_data, out6_last);
        end
    endtask

    task automatic test_rr_order();
        int n;
        int exp_ch;
        int exp_d;
        do_reset();
        mode = 1'b1; gate_pct = 100; ready_pct = 100;
        for (int k = 0; k < N; k++) begin
            src_q[k].push_back({1'b0, 8'((k << 4) | 0)});
            src_q[k].push_back({1'b1, 8'((k << 4) | 1)});
        end
        src_q[0].push_back({1'b0, 8'h02});
        src_q[0].push_back({1'b1, 8'h03});
        n = 0;
        while (obs_b.size() < 18 && n < 120) begin
            cycle();
            n++;
        end
        checks++;
        if (obs_b.size() != 18) begin
            errors++; $display("FAIL rr_beat_count got %0d exp 18", obs_b.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                exp_ch = (i < 16) ? i / 2 : 0;
                exp_d  = (i < 16) ? ((i / 2) << 4) | (i % 2) : i - 14;
                checks++; if (obs_ch[i] != exp_ch) begin errors++; $display("FAIL rr_ch[%0d] got %0d exp %0d", i, obs_ch[i], exp_ch); end
                checks++; if (obs_b[i].d !== 8'(exp_d) || obs_b[i].l !== 1'(i % 2)) begin
                    errors++; $display("FAIL rr_beat[%0d] got %h/%b exp %h/%b", i, obs_b[i].d, obs_b[i].l, 8'(exp_d), i % 2);
                end
                if (i > 0) begin
                    checks++; if (obs_cyc[i] - obs_cyc[i-1] != ((i % 2) ? 1 : 2)) begin
                        errors++; $display("FAIL rr_gap[%0d] got %0d exp %0d", i, obs_cyc[i] - obs_cyc[i-1], (i % 2) ? 1 : 2);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        mode = 1'b0; sel = 3'd2; gate_pct = 100; ready_pct = 100;
        for (int i = 0; i < 6; i++) src_q[2].push_back({i == 5, 8'(8'hC0 + i)});
        n = 0;
        while (obs_b.size() < 2 && n < 30) begin
            cycle();
            n++;
        end
        out_ready = 1'b0;
        ready_pct = 0;
        for (int s = 0; s < 3; s++) begin
            cycle();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hC2 || out_ch !== 3'd2 || out_last !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d l=%b exp v=1 d=c2 ch=2 l=0", s, out_valid, out_data, out_ch, out_last);
            end
            checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_in_ready[%0d] got %h exp 00", s, in_ready); end
        end
        ready_pct = 100;
        n = 0;
        while (obs_b.size() < 6 && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (obs_b.size() != 6) begin
            errors++; $display("FAIL bp_beat_count got %0d exp 6", obs_b.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (obs_b[i].d !== 8'(8'hC0 + i) || obs_b[i].l !== (i == 5) || obs_ch[i] != 2) begin
                    errors++; $display("FAIL bp_beat[%0d] got %h/%b ch%0d exp %h/%b ch2", i, obs_b[i].d, obs_b[i].l, obs_ch[i], 8'(8'hC0 + i), i == 5);
                end
            end
        end
    endtask

    task automatic test_reset_midpacket();
        int n;
        do_reset();
        mode = 1'b1; gate_pct = 100; ready_pct = 100;
        for (int i = 0; i < 10; i++) src_q[3].push_back({i == 9, 8'(8'h31 + i)});
        n = 0;
        while (obs_b.size() < 2 && n < 30) begin
            cycle();
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b exp 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || out_ch !== 3'd0) begin
            errors++; $display("FAIL rstmid_outputs got v=%b d=%h l=%b ch=%0d exp all 0", out_valid, out_data, out_last, out_ch);
        end
        checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL rstmid_in_ready got %h exp 00", in_ready); end
        do_reset();
        src_q[4].push_back({1'b1, 8'h44});
        src_q[0].push_back({1'b1, 8'h0A});
        n = 0;
        while (obs_b.size() < 2 && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (obs_b.size() != 2) begin
            errors++; $display("FAIL rstmid_beat_count got %0d exp 2", obs_b.size());
        end else begin
            checks++; if (obs_ch[0] != 0 || obs_ch[1] != 4) begin errors++; $display("FAIL rstmid_first_grant got %0d,%0d exp 0,4", obs_ch[0], obs_ch[1]); end
        end
    endtask

    task automatic test_random();
        int    open_ch;
        int    total_in;
        int    total_out;
        int    len;
        int    ch;
        bit    drained;
        beat_t b;
        beat_t e;
        do_reset();
        mode = 1'b1; gate_pct = 70; ready_pct = 70;
        open_ch = -1; total_in = 0; total_out = 0; drained = 1'b0;
        for (int c = 0; c < 11000 && !drained; c++) begin
            if (c < 10000) begin
                if (c % 64 == 0) begin
                    mode = 1'($urandom);
                    sel  = 3'($urandom);
                end
                for (int k = 0; k < N; k++) begin
                    if (src_q[k].size() == 0 && $urandom_range(99) < 20) begin
                        len = int'($urandom_range(4, 1));
                        for (int j = 0; j < len; j++) src_q[k].push_back({j == len - 1, 8'($urandom)});
                        total_in += len;
                    end
                end
            end else begin
                mode = 1'b1; gate_pct = 100; ready_pct = 100;
            end
            cycle();
            checks++; if ((in_ready & (in_ready - 8'd1)) != 8'h00) begin errors++; $display("FAIL rnd_ready_onehot got %b", in_ready); end
            while (obs_b.size() > 0) begin
                b  = obs_b.pop_front();
                ch = obs_ch.pop_front();
                void'(obs_cyc.pop_front());
                total_out++;
                checks++;
                if (exp_q[ch].size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected ch%0d got %h/%b exp nothing", ch, b.d, b.l);
                end else begin
                    e = exp_q[ch].pop_front();
                    if (b !== e) begin errors++; $display("FAIL rnd_order ch%0d got %h/%b exp %h/%b", ch, b.d, b.l, e.d, e.l); end
                end
                if (open_ch >= 0) begin
                    checks++; if (ch != open_ch) begin errors++; $display("FAIL rnd_atomic got ch%0d exp ch%0d", ch, open_ch); end
                end
                open_ch = b.l ? -1 : ch;
            end
            if (c >= 10000) begin
                drained = !out_valid;
                for (int k = 0; k < N; k++) if (src_q[k].size() != 0 || exp_q[k].size() != 0) drained = 1'b0;
            end
        end
        checks++; if (!drained) begin errors++; $display("FAIL rnd_drain got pending beats exp none"); end
        checks++; if (total_out != total_in) begin errors++; $display("FAIL rnd_total got %0d exp %0d", total_out, total_in); end
    endtask

    initial begin
        mode = 1'b1; sel = '0;
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_mode0();
        test_sel_invalid();
        test_rr_order();
        test_backpressure();
        test_reset_midpacket();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
